// File: rtl/tl_mem_responder_if.sv
// A/D channel bundle between a TileLink-style initiator and the memory responder.
interface tl_mem_responder_if #(
  parameter int unsigned a_channel_size = 53,
  parameter int unsigned d_channel_size = 43
);
  logic [a_channel_size-1:0] a_channel;
  logic                      a_valid;
  logic                      a_ready;
  logic [d_channel_size-1:0] d_channel;
  logic                      d_valid;
  logic                      d_ready;
  logic                      backpressureslave;
  logic                      d_error;

  modport master (
    output a_channel, a_valid, d_ready,
    input  a_ready, d_channel, d_valid, backpressureslave, d_error
  );

  modport slave (
    input  a_channel, a_valid, d_ready,
    output a_ready, d_channel, d_valid, backpressureslave, d_error
  );
endinterface

// File: rtl/tl_mem_responder.sv
// Memory responder: 2-entry request FIFO feeding an IDLE/EXEC/RESP engine
// over a 32-bit word memory with byte-lane writes and access denial.
module tl_mem_responder #(
  parameter int unsigned a_channel_size = 53,
  parameter int unsigned d_channel_size = 43,
  parameter int unsigned MEM_WORDS      = 256
) (
  input  logic                clk,
  input  logic                reset,
  tl_mem_responder_if.slave   bus
);

  localparam int unsigned AW = a_channel_size;
  localparam int unsigned DW = d_channel_size;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0] fifo_mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  logic          full, empty, push, pop;

  logic [AW-1:0] exec_req;
  logic [DW-1:0] d_channel_q;
  logic          d_valid_q, d_error_q;

  logic [31:0]   mem [MEM_WORDS];

  logic [2:0]    req_op;
  logic [1:0]    req_size;
  logic [15:0]   req_addr;
  logic [31:0]   req_data;
  logic          is_put, is_get, misaligned, denied, wr_en;
  logic [3:0]    lane_mask;
  logic [31:0]   rd_word, rsp_data;
  logic [2:0]    rsp_op;
  logic [DW-1:0] rsp;

  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
  assign push  = bus.a_valid && !full;
  assign pop   = (state == IDLE) && !empty;

  assign bus.a_ready           = !full;
  assign bus.backpressureslave = full;
  assign bus.d_channel         = d_channel_q;
  assign bus.d_valid           = d_valid_q;
  assign bus.d_error           = d_error_q;

  // FIFO pointers and occupancy; push and pop may coincide at count 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.a_channel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.d_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    exec_req <= '0;
    else if (pop) exec_req <= fifo_mem[rd_ptr];
  end

  // Decode the request under execution and build its response
  always_comb begin
    req_op     = exec_req[52:50];
    req_size   = exec_req[49:48];
    req_addr   = exec_req[47:32];
    req_data   = exec_req[31:0];
    is_put     = (req_op == 3'd0) || (req_op == 3'd1);
    is_get     = (req_op == 3'd4);
    misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                 ((req_size == 2'd2) && (req_addr[1:0] != 2'd0));
    denied     = (req_addr[15:10] != 6'd0) || (req_size == 2'd3) ||
                 misaligned || !(is_put || is_get);
    lane_mask  = 4'b0000;
    case (req_size)
      2'd0:    lane_mask = 4'b0001 << req_addr[1:0];
      2'd1:    lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
      2'd2:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
    wr_en    = (state == EXEC) && is_put && !denied;
    rd_word  = mem[req_addr[9:2]];
    rsp_op   = is_get ? 3'd1 : 3'd0;
    rsp_data = (is_get && !denied) ? rd_word : 32'd0;
    rsp      = DW'({rsp_op, req_size, 5'd0, denied, rsp_data});
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && lane_mask[i]) mem[req_addr[9:2]][8*i +: 8] <= req_data[8*i +: 8];
    end
  end

  // Response register: loaded in EXEC, held through RESP until accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_channel_q <= '0;
      d_valid_q   <= 1'b0;
      d_error_q   <= 1'b0;
    end else if (state == EXEC) begin
      d_channel_q <= rsp;
      d_valid_q   <= 1'b1;
      d_error_q   <= denied;
    end else if ((state == RESP) && bus.d_ready) begin
      d_valid_q   <= 1'b0;
      d_error_q   <= 1'b0;
    end
  end

endmodule
